id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage CPU; sits directly upstream of the execute-stage ALU/shifter block.
- Captures decoded operands, opcode, immediate, ALU control and write-back controls from ID.
- Presents ALU operands a/b (ALUSrc mux applied) to EX.
- Detects load-use hazards and inserts one bubble. Supports branch flush and downstream hold.

Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 5, register-file address width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs_data  input  DATA_W  rs read data
- id_rt_data  input  DATA_W  rt read data
- id_opcode  input  6  instruction opcode
- id_immed  input  16  instruction bits [15:0] (funct = [5:0], shamt = [10:6])
- id_alu_ctl  input  3  ALU control
- id_rs, id_rt, id_rd  input  REG_AW each  register specifiers
- id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  input  1 each  decoded controls
- flush  input  1  branch taken; kill the instruction in ID
- ex_hold  input  1  downstream stall; freeze this register
- stall_id  output  1  freeze PC and IF/ID (combinational)
- ex_valid  output  1  EX holds a real instruction
- ex_a  output  DATA_W  ALU operand a (rs data)
- ex_b  output  DATA_W  ALU operand b: sign-extended immed if alu_src, else rt data
- ex_store_data  output  DATA_W  rt data for stores
- ex_opcode  output  6  registered opcode
- ex_immed  output  16  registered immediate
- ex_alu_ctl  output  3  registered ALU control
- ex_rt  output  REG_AW  registered rt (used by hazard compare)
- ex_write_reg  output  REG_AW  rd if reg_dst, else rt
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  output  1 each  registered controls

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output = 0, including ex_valid=0. Registers then hold a bubble.
- Latency: 1 cycle. ID values on edge N appear on ex_* after edge N.
- ex_b is formed at capture: alu_src=1 -> {{16{immed[15]}}, immed}; else id_rt_data. Same rule for both widths when DATA_W=32.
- ex_write_reg is formed at capture: id_reg_dst ? id_rd : id_rt.
- Load-use hazard (combinational): haz = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt).
- stall_id = ex_hold | (haz & ~flush).
- Per-edge update priority:
  1. ex_hold=1: all registers keep their value. flush and haz are ignored; the flush source keeps flush asserted until hold drops.
  2. flush=1: load a bubble.
  3. haz=1: load a bubble. ID is frozen via stall_id and re-presents the same instruction next cycle.
  4. Otherwise: capture ID with ex_valid = id_valid.
- Bubble: ex_valid=0, ex_mem_read/mem_write/reg_write/mem_to_reg=0, ex_write_reg=0. Data fields are don't-care; implementation drives 0.
- An id_valid=0 capture also forces all control outputs to 0.
- Only one bubble per load: after the bubble, ex_mem_read=0, so haz clears and the dependent instruction advances.
- Back-to-back loads chained through rt follow the same rule: each dependent instruction stalls exactly one cycle.
- Register 0 never triggers a hazard.
- Reset asserted mid-stall clears the bubble and hold state immediately. stall_id then follows ex_hold only.

Optional Feature:
- Macro IDEX_BUBBLE_CNT_EN.
- Defined: adds output bubble_cnt [31:0], reset 0. It increments by 1 on each edge where a hazard bubble is loaded (priority 3 only; flush and hold do not count) and wraps at 2^32.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive inputs nonzero, rst_n=0 between edges -> all ex_* = 0 immediately, stall_id = ex_hold.
- Plain capture: addi with rs_data=5, immed=16'hFFFE, alu_src=1, reg_dst=0, rt=8 -> next cycle ex_a=5, ex_b=32'hFFFFFFFE, ex_write_reg=8, ex_valid=1.
- Load-use: lw writing rt=9, then add with rs=9 -> stall_id=1 for exactly one cycle; the add reaches ex_valid=1 one cycle late; the intervening cycle has ex_valid=0, ex_reg_write=0.
- Register-zero: lw with rt=0 followed by a reader of $0 -> stall_id=0, no bubble.
- Flush vs hazard: flush=1 while haz=1 -> bubble loaded, stall_id=0; the next ID instruction is captured the following cycle.
- Hold: ex_hold=1 for 3 cycles with a flush pulse inside -> ex_* constant, stall_id=1 throughout; with the feature enabled, bubble_cnt is unchanged.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
// Captures decoded operands and controls from ID and presents the ALU
// operands (with the ALUSrc mux already applied) to EX. A load-use hazard
// inserts a one-cycle bubble. A branch flush also inserts a bubble, and a
// downstream hold freezes the register.
// Optional build macro IDEX_BUBBLE_CNT_EN adds the bubble_cnt output, a
// free-running count of the bubbles caused by load-use hazards.
module id_ex_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [5:0]        id_opcode,
   input  logic [15:0]       id_immed,
   input  logic [2:0]        id_alu_ctl,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_dst,
   input  logic              id_alu_src,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_reg_write,
   input  logic              id_mem_to_reg,
   input  logic              flush,
   input  logic              ex_hold,
   output logic              stall_id,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [5:0]        ex_opcode,
   output logic [15:0]       ex_immed,
   output logic [2:0]        ex_alu_ctl,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_write_reg,
`ifdef IDEX_BUBBLE_CNT_EN
   output logic [31:0]       bubble_cnt,
`endif
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg
);

   logic              haz;
   logic              load_bubble;
   logic [DATA_W-1:0] imm_sext;

   // Load-use detection against the load currently in EX; $0 never conflicts.
   always_comb begin
      haz = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
            ((ex_rt == id_rs) | (ex_rt == id_rt));
      // A taken branch kills the dependent instruction, so ID must not freeze.
      stall_id = ex_hold | (haz & ~flush);
      // An invalid ID slot is loaded exactly like a bubble.
      load_bubble = flush | haz | ~id_valid;
      imm_sext = {{(DATA_W-16){id_immed[15]}}, id_immed};
   end

   // Pipeline register: hold beats flush beats hazard beats capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ex_a          <= '0;
         ex_b          <= '0;
         ex_store_data <= '0;
         ex_opcode     <= '0;
         ex_immed      <= '0;
         ex_alu_ctl    <= '0;
         ex_rt         <= '0;
         ex_write_reg  <= '0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
      end else if (!ex_hold) begin
         if (load_bubble) begin
            ex_valid      <= 1'b0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_opcode     <= '0;
            ex_immed      <= '0;
            ex_alu_ctl    <= '0;
            ex_rt         <= '0;
            ex_write_reg  <= '0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
         end else begin
            ex_valid      <= 1'b1;
            ex_a          <= id_rs_data;
            ex_b          <= id_alu_src ? imm_sext : id_rt_data;
            ex_store_data <= id_rt_data;
            ex_opcode     <= id_opcode;
            ex_immed      <= id_immed;
            ex_alu_ctl    <= id_alu_ctl;
            ex_rt         <= id_rt;
            ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg;
         end
      end
   end

`ifdef IDEX_BUBBLE_CNT_EN
   // Count only hazard bubbles; flush and hold edges are excluded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_cnt <= '0;
      else if (!ex_hold && !flush && haz)
         bubble_cnt <= bubble_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed vector bench for id_ex_reg: a scripted table of ID inputs with
// hand-computed EX outputs, plus reset sequences applied between edges.
module tb_id_ex_reg;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_rs_data, id_rt_data;
   logic [5:0]  id_opcode;
   logic [15:0] id_immed;
   logic [2:0]  id_alu_ctl;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_reg_dst, id_alu_src, id_mem_read, id_mem_write;
   logic        id_reg_write, id_mem_to_reg;
   logic        flush, ex_hold;
   logic        stall_id, ex_valid;
   logic [31:0] ex_a, ex_b, ex_store_data;
   logic [5:0]  ex_opcode;
   logic [15:0] ex_immed;
   logic [2:0]  ex_alu_ctl;
   logic [4:0]  ex_rt, ex_write_reg;
   logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
`ifdef IDEX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt;
`endif

   id_ex_reg #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_opcode(id_opcode), .id_immed(id_immed), .id_alu_ctl(id_alu_ctl),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
      .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
      .ex_store_data(ex_store_data), .ex_opcode(ex_opcode),
      .ex_immed(ex_immed), .ex_alu_ctl(ex_alu_ctl), .ex_rt(ex_rt),
      .ex_write_reg(ex_write_reg),
`ifdef IDEX_BUBBLE_CNT_EN
      .bubble_cnt(bubble_cnt),
`endif
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // c    = {reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg}
   // e_ctl = {mem_read, mem_write, reg_write, mem_to_reg}
   // cap  = the vector's own ID fields are expected on opcode/immed/alu_ctl/rt
   typedef struct {
      logic        v;
      logic [31:0] rsd, rtd;
      logic [5:0]  op;
      logic [15:0] imm;
      logic [2:0]  ctl;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  c;
      logic        fl, hd;
      logic        e_stall, e_valid;
      logic [31:0] e_a, e_b, e_st;
      logic [4:0]  e_wr;
      logic [3:0]  e_ctl;
      logic [31:0] e_cnt;
      logic        cap;
   } vec_t;

   localparam logic [5:0] C_ADDI = 6'b010010;
   localparam logic [5:0] C_R    = 6'b100010;
   localparam logic [5:0] C_LW   = 6'b011011;
   localparam logic [3:0] E_ALU  = 4'b0010;
   localparam logic [3:0] E_LW   = 4'b1011;
   localparam logic [3:0] E_NONE = 4'b0000;

   vec_t tbl[22];
   vec_t w;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         $display("FAIL %s: got %h, want %h", name, act, exp);
         n_err++;
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid = t.v;   id_rs_data = t.rsd; id_rt_data = t.rtd;
      id_opcode = t.op; id_immed = t.imm;   id_alu_ctl = t.ctl;
      id_rs = t.rs;     id_rt = t.rt;       id_rd = t.rd;
      {id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg} = t.c;
      flush = t.fl;     ex_hold = t.hd;
   endtask

   task automatic check_ex(input string tag, input vec_t t);
      chk({tag, " ex_valid"}, {31'd0, ex_valid}, {31'd0, t.e_valid});
      chk({tag, " ctl"}, {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg},
          {28'd0, t.e_ctl});
      chk({tag, " write_reg"}, {27'd0, ex_write_reg}, {27'd0, t.e_wr});
      if (t.e_valid) begin
         chk({tag, " ex_a"}, ex_a, t.e_a);
         chk({tag, " ex_b"}, ex_b, t.e_b);
         chk({tag, " store"}, ex_store_data, t.e_st);
      end
      if (t.cap) begin
         chk({tag, " opcode"}, {26'd0, ex_opcode}, {26'd0, t.op});
         chk({tag, " immed"}, {16'd0, ex_immed}, {16'd0, t.imm});
         chk({tag, " alu_ctl"}, {29'd0, ex_alu_ctl}, {29'd0, t.ctl});
         chk({tag, " ex_rt"}, {27'd0, ex_rt}, {27'd0, t.rt});
      end
`ifdef IDEX_BUBBLE_CNT_EN
      chk({tag, " bubble_cnt"}, bubble_cnt, t.e_cnt);
`endif
   endtask

   // One vector: drive mid-cycle, check stall_id before the edge, outputs after.
   task automatic apply(input string tag, input vec_t t);
      @(negedge clk);
      drive(t);
      #1;
      chk({tag, " stall_id"}, {31'd0, stall_id}, {31'd0, t.e_stall});
      @(posedge clk);
      #1;
      check_ex(tag, t);
      n_vec++;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
      chk({tag, " ex_a"}, ex_a, 32'd0);
      chk({tag, " ex_b"}, ex_b, 32'd0);
      chk({tag, " store"}, ex_store_data, 32'd0);
      chk({tag, " op/imm/alu"}, {7'd0, ex_opcode, ex_immed, ex_alu_ctl}, 32'd0);
      chk({tag, " rt/wr"}, {22'd0, ex_rt, ex_write_reg}, 32'd0);
      chk({tag, " ctl"}, {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 32'd0);
`ifdef IDEX_BUBBLE_CNT_EN
      chk({tag, " bubble_cnt"}, bubble_cnt, 32'd0);
`endif
   endtask

   initial begin
      // addi / add / lw + dependent add
      tbl[0]  = '{1'b1, 32'd5, 32'h77, 6'h08, 16'hFFFE, 3'd2, 5'd1, 5'd8, 5'd0, C_ADDI, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd5, 32'hFFFFFFFE, 32'h77, 5'd8, E_ALU, 32'd0, 1'b1};
      tbl[1]  = '{1'b1, 32'd10, 32'd20, 6'h00, 16'h2020, 3'd2, 5'd2, 5'd3, 5'd4, C_R, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd10, 32'd20, 32'd20, 5'd4, E_ALU, 32'd0, 1'b1};
      tbl[2]  = '{1'b1, 32'd100, 32'h55, 6'h23, 16'h0004, 3'd2, 5'd2, 5'd9, 5'd0, C_LW, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd100, 32'd4, 32'h55, 5'd9, E_LW, 32'd0, 1'b1};
      tbl[3]  = '{1'b1, 32'd1, 32'd2, 6'h00, 16'h5020, 3'd2, 5'd9, 5'd3, 5'd10, C_R, 1'b0, 1'b0,
                  1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, E_NONE, 32'd1, 1'b0};
      tbl[4]  = '{1'b1, 32'd1, 32'd2, 6'h00, 16'h5020, 3'd2, 5'd9, 5'd3, 5'd10, C_R, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd1, 32'd2, 32'd2, 5'd10, E_ALU, 32'd1, 1'b1};
      // lw to $0 then a reader of $0: no hazard
      tbl[5]  = '{1'b1, 32'd7, 32'd0, 6'h23, 16'h0008, 3'd2, 5'd2, 5'd0, 5'd0, C_LW, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd7, 32'd8, 32'd0, 5'd0, E_LW, 32'd1, 1'b1};
      tbl[6]  = '{1'b1, 32'd0, 32'd3, 6'h00, 16'h3020, 3'd2, 5'd0, 5'd5, 5'd6, C_R, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd0, 32'd3, 32'd3, 5'd6, E_ALU, 32'd1, 1'b1};
      // chained loads: lw r12; lw r13 <- [r12]; add uses r13 via rt
      tbl[7]  = '{1'b1, 32'd40, 32'h99, 6'h23, 16'hFFFC, 3'd2, 5'd1, 5'd12, 5'd0, C_LW, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd40, 32'hFFFFFFFC, 32'h99, 5'd12, E_LW, 32'd1, 1'b1};
      tbl[8]  = '{1'b1, 32'd50, 32'h11, 6'h23, 16'h0000, 3'd2, 5'd12, 5'd13, 5'd0, C_LW, 1'b0, 1'b0,
                  1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, E_NONE, 32'd2, 1'b0};
      tbl[9]  = '{1'b1, 32'd50, 32'h11, 6'h23, 16'h0000, 3'd2, 5'd12, 5'd13, 5'd0, C_LW, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd50, 32'd0, 32'h11, 5'd13, E_LW, 32'd2, 1'b1};
      tbl[10] = '{1'b1, 32'd3, 32'd4, 6'h00, 16'h7020, 3'd2, 5'd4, 5'd13, 5'd14, C_R, 1'b0, 1'b0,
                  1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, E_NONE, 32'd3, 1'b0};
      tbl[11] = '{1'b1, 32'd3, 32'd4, 6'h00, 16'h7020, 3'd2, 5'd4, 5'd13, 5'd14, C_R, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd3, 32'd4, 32'd4, 5'd14, E_ALU, 32'd3, 1'b1};
      // flush while a hazard is present, then the next instruction
      tbl[12] = '{1'b1, 32'd60, 32'h44, 6'h23, 16'h0004, 3'd2, 5'd1, 5'd15, 5'd0, C_LW, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd60, 32'd4, 32'h44, 5'd15, E_LW, 32'd3, 1'b1};
      tbl[13] = '{1'b1, 32'd8, 32'd9, 6'h00, 16'h8020, 3'd2, 5'd15, 5'd2, 5'd16, C_R, 1'b1, 1'b0,
                  1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, E_NONE, 32'd3, 1'b0};
      tbl[14] = '{1'b1, 32'd6, 32'd9, 6'h00, 16'h8825, 3'd1, 5'd3, 5'd4, 5'd17, C_R, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd6, 32'd9, 32'd9, 5'd17, E_ALU, 32'd3, 1'b1};
      // id_valid=0 with every control set: captured as a bubble
      tbl[15] = '{1'b0, 32'hAA, 32'hBB, 6'h23, 16'h1234, 3'd2, 5'd9, 5'd9, 5'd9, 6'b111111, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, E_NONE, 32'd3, 1'b0};
      // lw r20, then hold 3 cycles (flush pulse inside) with a dependent add in ID
      tbl[16] = '{1'b1, 32'd80, 32'h33, 6'h23, 16'h0010, 3'd2, 5'd1, 5'd20, 5'd0, C_LW, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd80, 32'd16, 32'h33, 5'd20, E_LW, 32'd3, 1'b1};
      tbl[17] = '{1'b1, 32'd1, 32'd2, 6'h00, 16'hA820, 3'd2, 5'd20, 5'd2, 5'd21, C_R, 1'b0, 1'b1,
                  1'b1, 1'b1, 32'd80, 32'd16, 32'h33, 5'd20, E_LW, 32'd3, 1'b0};
      tbl[18] = '{1'b1, 32'd1, 32'd2, 6'h00, 16'hA820, 3'd2, 5'd20, 5'd2, 5'd21, C_R, 1'b1, 1'b1,
                  1'b1, 1'b1, 32'd80, 32'd16, 32'h33, 5'd20, E_LW, 32'd3, 1'b0};
      tbl[19] = '{1'b1, 32'd1, 32'd2, 6'h00, 16'hA820, 3'd2, 5'd20, 5'd2, 5'd21, C_R, 1'b1, 1'b1,
                  1'b1, 1'b1, 32'd80, 32'd16, 32'h33, 5'd20, E_LW, 32'd3, 1'b0};
      tbl[20] = '{1'b1, 32'd1, 32'd2, 6'h00, 16'hA820, 3'd2, 5'd20, 5'd2, 5'd21, C_R, 1'b1, 1'b0,
                  1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, E_NONE, 32'd3, 1'b0};
      tbl[21] = '{1'b1, 32'd11, 32'd12, 6'h00, 16'hB020, 3'd2, 5'd5, 5'd6, 5'd22, C_R, 1'b0, 1'b0,
                  1'b0, 1'b1, 32'd11, 32'd12, 32'd12, 5'd22, E_ALU, 32'd3, 1'b1};

      // Reset with nonzero inputs: outputs zero, stall_id follows ex_hold only
      rst_n = 1'b0;
      w = tbl[2];
      w.rt = 5'd7; w.rs = 5'd7;
      drive(w);
      #12;
      check_all_zero("reset");
      chk("reset stall_id hold=0", {31'd0, stall_id}, 32'd0);
      ex_hold = 1'b1;
      #1;
      chk("reset stall_id hold=1", {31'd0, stall_id}, 32'd1);
      ex_hold = 1'b0;
      n_vec++;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++)
         apply($sformatf("vec%0d", i), tbl[i]);

      // Reset asserted while a load-use stall is pending
      w = tbl[16];
      w.e_cnt = 32'd3;
      apply("pre-rst lw", w);
      @(negedge clk);
      drive(tbl[17]);
      ex_hold = 1'b0;
      flush = 1'b0;
      #1;
      chk("midrst stall before", {31'd0, stall_id}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      chk("midrst stall_id", {31'd0, stall_id}, 32'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      w = tbl[17];
      w.hd = 1'b0; w.e_valid = 1'b1; w.e_a = 32'd1; w.e_b = 32'd2; w.e_st = 32'd2;
      w.e_wr = 5'd21; w.e_ctl = E_ALU; w.e_cnt = 32'd0; w.cap = 1'b1;
      check_ex("postrst add", w);
      n_vec++;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
